// File: rtl/gpio_ctrl_if.sv
// Register-bus bundle between the system bus master and gpio_ctrl.
// Reads return one cycle after rd_en. The slave never stalls, so there is no backpressure.
interface gpio_ctrl_if #(
  parameter int GPIO_WIDTH = 16
);
  logic                  wr_en;
  logic                  rd_en;
  logic [2:0]            addr;
  logic [GPIO_WIDTH-1:0] wdata;
  logic [GPIO_WIDTH-1:0] rdata;
  logic                  rd_valid;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, rd_valid
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, rd_valid
  );
endinterface

// File: rtl/gpio_ctrl.sv
// GPIO register block: pad output/tristate, synchronised input, sticky edge flags and level irq.
// Writes land on the strobe edge and reads respond one cycle later; the block never stalls the bus.
module gpio_ctrl #(
  parameter int GPIO_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gpio_ctrl_if.slave            bus,
  output logic                  irq,
  output logic [GPIO_WIDTH-1:0] gpio_write,
  output logic [GPIO_WIDTH-1:0] gpio_status,
  input  logic [GPIO_WIDTH-1:0] gpio_read
);

  localparam logic [2:0] ADDR_OUT  = 3'd0;
  localparam logic [2:0] ADDR_TRI  = 3'd1;
  localparam logic [2:0] ADDR_IN   = 3'd2;
  localparam logic [2:0] ADDR_STAT = 3'd3;
  localparam logic [2:0] ADDR_IEN  = 3'd4;
  localparam logic [2:0] ADDR_POL  = 3'd5;

  logic [GPIO_WIDTH-1:0] out_q,   out_d;
  logic [GPIO_WIDTH-1:0] tri_q,   tri_d;
  logic [GPIO_WIDTH-1:0] stat_q,  stat_d;
  logic [GPIO_WIDTH-1:0] ien_q,   ien_d;
  logic [GPIO_WIDTH-1:0] pol_q,   pol_d;
  logic [GPIO_WIDTH-1:0] prev_q,  prev_d;
  logic [GPIO_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  irq_q,      irq_d;

  // Stage 0 takes the raw pad value; the last stage is the synchronised pin value.
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q, sync_d;

  logic [GPIO_WIDTH-1:0] sync_val;
  logic [GPIO_WIDTH-1:0] rise_evt;
  logic [GPIO_WIDTH-1:0] fall_evt;
  logic [GPIO_WIDTH-1:0] edge_evt;
  logic [GPIO_WIDTH-1:0] w1c_mask;
  logic                  wr_out, wr_tri, wr_stat, wr_ien, wr_pol;

  always_comb begin
    sync_val = sync_q[SYNC_STAGES-1];
    rise_evt = sync_val & ~prev_q;
    fall_evt = ~sync_val & prev_q;
    edge_evt = (fall_evt & pol_q) | (rise_evt & ~pol_q);

    wr_out  = bus.wr_en && (bus.addr == ADDR_OUT);
    wr_tri  = bus.wr_en && (bus.addr == ADDR_TRI);
    wr_stat = bus.wr_en && (bus.addr == ADDR_STAT);
    wr_ien  = bus.wr_en && (bus.addr == ADDR_IEN);
    wr_pol  = bus.wr_en && (bus.addr == ADDR_POL);
    w1c_mask = wr_stat ? bus.wdata : '0;
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], gpio_read};
    prev_d = sync_val;

    out_d = wr_out ? bus.wdata : out_q;
    tri_d = wr_tri ? bus.wdata : tri_q;
    ien_d = wr_ien ? bus.wdata : ien_q;
    pol_d = wr_pol ? bus.wdata : pol_q;

    // A new event outranks a same-cycle clear so no edge is ever lost.
    stat_d = (stat_q & ~w1c_mask) | edge_evt;

    irq_d = |(stat_q & ien_q);
  end

  // Read mux samples pre-write register state so a simultaneous write is not visible yet.
  always_comb begin
    rd_valid_d = bus.rd_en;
    rdata_d    = '0;
    if (bus.rd_en) begin
      case (bus.addr)
        ADDR_OUT:  rdata_d = out_q;
        ADDR_TRI:  rdata_d = tri_q;
        ADDR_IN:   rdata_d = sync_val;
        ADDR_STAT: rdata_d = stat_q;
        ADDR_IEN:  rdata_d = ien_q;
        ADDR_POL:  rdata_d = pol_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      out_q      <= '0;
      tri_q      <= '1;
      stat_q     <= '0;
      ien_q      <= '0;
      pol_q      <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      out_q      <= out_d;
      tri_q      <= tri_d;
      stat_q     <= stat_d;
      ien_q      <= ien_d;
      pol_q      <= pol_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign gpio_write   = out_q;
  assign gpio_status  = tri_q;
  assign irq          = irq_q;
  assign bus.rdata    = rdata_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus randomized traffic against a register-level model.
module tb_gpio_ctrl;
  localparam int W = 16;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         irq;
  logic [W-1:0] gpio_write;
  logic [W-1:0] gpio_status;
  logic [W-1:0] gpio_read = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpio_ctrl_if #(.GPIO_WIDTH(W)) bus ();

  gpio_ctrl #(.GPIO_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .irq         (irq),
    .gpio_write  (gpio_write),
    .gpio_status (gpio_status),
    .gpio_read   (gpio_read)
  );

  // Register-level model. hist[k] is the pad value sampled k+1 edges ago.
  logic [W-1:0] m_out, m_tri, m_stat, m_ien, m_pol, m_rdata;
  logic         m_rv, m_irq;
  logic [W-1:0] hist [8];

  function automatic logic [W-1:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0:    return m_out;
      3'd1:    return m_tri;
      3'd2:    return hist[S-1];
      3'd3:    return m_stat;
      3'd4:    return m_ien;
      3'd5:    return m_pol;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_out = '0; m_tri = '1; m_stat = '0; m_ien = '0; m_pol = '0;
    m_rdata = '0; m_rv = 1'b0; m_irq = 1'b0;
    for (int i = 0; i < 8; i++) hist[i] = '0;
  endtask

  task automatic model_edge(input logic wr, input logic rd, input logic [2:0] a,
                            input logic [W-1:0] wd, input logic [W-1:0] pin);
    logic [W-1:0] now_v, old_v, ev, clr;
    now_v = hist[S-1];
    old_v = hist[S];
    ev = (m_pol & old_v & ~now_v) | (~m_pol & now_v & ~old_v);
    m_rv    = rd;
    m_rdata = rd ? m_reg(a) : '0;
    m_irq   = |(m_stat & m_ien);
    clr     = (wr && a == 3'd3) ? wd : '0;
    m_stat  = (m_stat & ~clr) | ev;
    if (wr) begin
      case (a)
        3'd0: m_out = wd;
        3'd1: m_tri = wd;
        3'd4: m_ien = wd;
        3'd5: m_pol = wd;
        default: ;
      endcase
    end
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pin;
  endtask

  // Drives one bus cycle, advances DUT and model by one edge, returns at edge+1.
  task automatic tick(input logic wr, input logic rd, input logic [2:0] a, input logic [W-1:0] wd);
    bus.wr_en = wr; bus.rd_en = rd; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    model_edge(wr, rd, a, wd, gpio_read);
    #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_rst [8];
    exp_rst = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gpio_read = W'($urandom);
    end
    @(posedge clk); #1;
    gpio_read = '0;
    total++; if (gpio_status !== 16'hFFFF) begin bad++; $display("FAIL reset_status got=%h want=ffff", gpio_status); end
    total++; if (gpio_write !== 16'h0000) begin bad++; $display("FAIL reset_write got=%h want=0000", gpio_write); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    total++; if (bus.rdata !== 16'h0000 || bus.rd_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rdata got=%h/%b want=0000/0", bus.rdata, bus.rd_valid);
    end
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      tick(1'b0, 1'b1, 3'(a), '0);
      total++; if (bus.rd_valid !== 1'b1 || bus.rdata !== exp_rst[a]) begin
        bad++; $display("FAIL reset_read addr=%0d got=%h/%b want=%h/1", a, bus.rdata, bus.rd_valid, exp_rst[a]);
      end
    end
    tick(1'b0, 1'b0, 3'd0, '0);
    total++; if (bus.rd_valid !== 1'b0 || bus.rdata !== 16'h0000) begin
      bad++; $display("FAIL idle_rdata got=%h/%b want=0000/0", bus.rdata, bus.rd_valid);
    end
  endtask

  task automatic test_output();
    tick(1'b1, 1'b0, 3'd0, 16'hA5A5);
    total++; if (gpio_write !== 16'hA5A5) begin bad++; $display("FAIL out_pin got=%h want=a5a5", gpio_write); end
    tick(1'b1, 1'b0, 3'd1, 16'hFF00);
    total++; if (gpio_status !== 16'hFF00) begin bad++; $display("FAIL tri_pin got=%h want=ff00", gpio_status); end
    tick(1'b0, 1'b1, 3'd0, '0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rdata !== 16'hA5A5) begin
      bad++; $display("FAIL out_read got=%h/%b want=a5a5/1", bus.rdata, bus.rd_valid);
    end
    tick(1'b0, 1'b1, 3'd1, '0);
    total++; if (bus.rd_valid !== 1'b1 || bus.rdata !== 16'hFF00) begin
      bad++; $display("FAIL tri_read got=%h/%b want=ff00/1", bus.rdata, bus.rd_valid);
    end
  endtask

  task automatic test_sync_latency();
    tick(1'b1, 1'b0, 3'd4, 16'h0008);
    gpio_read = 16'h0008;
    tick(1'b0, 1'b1, 3'd2, '0);   // E0
    total++; if (bus.rdata !== 16'h0000) begin bad++; $display("FAIL in_e0 got=%h want=0000", bus.rdata); end
    tick(1'b0, 1'b1, 3'd2, '0);   // E0+1
    total++; if (bus.rdata !== 16'h0000) begin bad++; $display("FAIL in_e1 got=%h want=0000", bus.rdata); end
    tick(1'b0, 1'b1, 3'd3, '0);   // E0+2
    total++; if (bus.rdata !== 16'h0000 || irq !== 1'b0) begin
      bad++; $display("FAIL stat_e2 got=%h irq=%b want=0000 irq=0", bus.rdata, irq);
    end
    tick(1'b0, 1'b1, 3'd2, '0);   // E0+3
    total++; if (bus.rdata !== 16'h0008 || irq !== 1'b1) begin
      bad++; $display("FAIL in_e3 got=%h irq=%b want=0008 irq=1", bus.rdata, irq);
    end
    tick(1'b0, 1'b1, 3'd3, '0);
    total++; if (bus.rdata !== 16'h0008) begin bad++; $display("FAIL stat_e4 got=%h want=0008", bus.rdata); end
  endtask

  task automatic test_falling_mask();
    tick(1'b1, 1'b0, 3'd4, 16'h0000);
    tick(1'b1, 1'b0, 3'd3, 16'hFFFF);
    tick(1'b1, 1'b0, 3'd5, 16'h0001);
    gpio_read = 16'h0009;
    for (int i = 0; i < S + 2; i++) tick(1'b0, 1'b0, 3'd0, '0);
    tick(1'b0, 1'b1, 3'd3, '0);
    total++; if (bus.rdata !== 16'h0000) begin bad++; $display("FAIL rise_ignored got=%h want=0000", bus.rdata); end
    gpio_read = 16'h0008;
    for (int i = 0; i < S + 2; i++) tick(1'b0, 1'b0, 3'd0, '0);
    tick(1'b0, 1'b1, 3'd3, '0);
    total++; if (bus.rdata !== 16'h0001 || irq !== 1'b0) begin
      bad++; $display("FAIL fall_masked got=%h irq=%b want=0001 irq=0", bus.rdata, irq);
    end
    tick(1'b1, 1'b0, 3'd4, 16'h0001);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL unmask_early got=%b want=0", irq); end
    tick(1'b0, 1'b0, 3'd0, '0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL unmask_irq got=%b want=1", irq); end
  endtask

  task automatic test_w1c_race();
    tick(1'b1, 1'b0, 3'd5, 16'h0000);
    tick(1'b1, 1'b0, 3'd4, 16'h0020);
    tick(1'b1, 1'b0, 3'd3, 16'hFFFF);
    gpio_read = 16'h0028;
    for (int i = 0; i < S + 2; i++) tick(1'b0, 1'b0, 3'd0, '0);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL race_pre_irq got=%b want=1", irq); end
    gpio_read = 16'h0008;
    for (int i = 0; i < S + 2; i++) tick(1'b0, 1'b0, 3'd0, '0);
    gpio_read = 16'h0028;
    tick(1'b0, 1'b0, 3'd0, '0);                     // pin change captured here
    for (int i = 0; i < S - 1; i++) tick(1'b0, 1'b0, 3'd0, '0);
    tick(1'b1, 1'b0, 3'd3, 16'h0020);               // clear lands with the new event
    tick(1'b0, 1'b1, 3'd3, '0);
    total++; if (bus.rdata !== 16'h0020 || irq !== 1'b1) begin
      bad++; $display("FAIL race_set_wins got=%h irq=%b want=0020 irq=1", bus.rdata, irq);
    end
    tick(1'b1, 1'b0, 3'd3, 16'h0020);
    tick(1'b0, 1'b1, 3'd3, '0);
    total++; if (bus.rdata !== 16'h0000 || irq !== 1'b0) begin
      bad++; $display("FAIL race_clear got=%h irq=%b want=0000 irq=0", bus.rdata, irq);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b1, 3'd0, 16'h1234);
    total++; if (bus.rdata !== m_rdata || gpio_write !== 16'h1234) begin
      bad++; $display("FAIL wr_rd_same got=%h pin=%h want=%h pin=1234", bus.rdata, gpio_write, m_rdata);
    end
    for (int a = 0; a < 8; a++) begin
      tick(1'b0, 1'b1, 3'(a), '0);
      total++; if (bus.rd_valid !== 1'b1 || bus.rdata !== m_rdata) begin
        bad++; $display("FAIL b2b addr=%0d got=%h/%b want=%h/1", a, bus.rdata, bus.rd_valid, m_rdata);
      end
    end
  endtask

  task automatic test_reserved_reset_mid();
    logic [W-1:0] out_before, tri_before;
    out_before = gpio_write;
    tri_before = gpio_status;
    tick(1'b1, 1'b1, 3'd6, 16'hFFFF);
    total++; if (bus.rdata !== 16'h0000 || bus.rd_valid !== 1'b1) begin
      bad++; $display("FAIL rsv_read got=%h/%b want=0000/1", bus.rdata, bus.rd_valid);
    end
    tick(1'b0, 1'b1, 3'd7, '0);
    total++; if (bus.rdata !== 16'h0000 || gpio_write !== out_before || gpio_status !== tri_before) begin
      bad++; $display("FAIL rsv_nochange got=%h out=%h tri=%h want=0000 out=%h tri=%h",
                      bus.rdata, gpio_write, gpio_status, out_before, tri_before);
    end
    tick(1'b1, 1'b0, 3'd0, 16'hFFFF);
    tick(1'b1, 1'b0, 3'd4, 16'hFFFF);
    bus.rd_en = 1'b1; bus.addr = 3'd0;
    #2 rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      total++; if (bus.rd_valid !== 1'b0 || bus.rdata !== 16'h0000 || gpio_write !== 16'h0000 ||
                   gpio_status !== 16'hFFFF || irq !== 1'b0) begin
        bad++; $display("FAIL mid_reset rv=%b rd=%h out=%h tri=%h irq=%b want 0/0000/0000/ffff/0",
                        bus.rd_valid, bus.rdata, gpio_write, gpio_status, irq);
      end
    end
    bus.rd_en = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      tick(1'b0, 1'b1, 3'(a), '0);
      total++; if (bus.rdata !== m_rdata) begin
        bad++; $display("FAIL post_reset addr=%0d got=%h want=%h", a, bus.rdata, m_rdata);
      end
    end
  endtask

  task automatic test_random();
    logic         wr, rd;
    logic [2:0]   a;
    logic [W-1:0] wd;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) gpio_read = gpio_read ^ (W'(1) << $urandom_range(0, W-1));
      wr = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 1) == 0);
      a  = 3'($urandom_range(0, 7));
      wd = W'($urandom);
      tick(wr, rd, a, wd);
      total++; if (gpio_write !== m_out || gpio_status !== m_tri) begin
        bad++; $display("FAIL rnd_pins n=%0d got=%h/%h want=%h/%h", n, gpio_write, gpio_status, m_out, m_tri);
      end
      total++; if (irq !== m_irq) begin
        bad++; $display("FAIL rnd_irq n=%0d got=%b want=%b", n, irq, m_irq);
      end
      total++; if (bus.rd_valid !== m_rv || bus.rdata !== m_rdata) begin
        bad++; $display("FAIL rnd_read n=%0d got=%h/%b want=%h/%b", n, bus.rdata, bus.rd_valid, m_rdata, m_rv);
      end
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 3'd0; bus.wdata = '0;
    test_reset();
    test_output();
    test_sync_latency();
    test_falling_mask();
    test_w1c_race();
    test_back_to_back();
    test_reserved_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
